axi_lite_kernel_ctrl_slave: RTL and testbench

//  AXI-Lite responder on the kernel side of the action control path. It terminates the

---
 rtl/axi_lite_kernel_ctrl_pkg.sv | 28 ++
 rtl/axi_lite_slave_chan.sv | 116 +++++++++++
 rtl/axi_lite_kernel_ctrl_slave.sv | 168 ++++++++++++++++
 tb/tb_axi_lite_kernel_ctrl_slave.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_kernel_ctrl_pkg.sv
// Shared register map, CTRL bit positions, response codes and kernel FSM states
// for the kernel-side AXI-Lite control slave.
package axi_lite_kernel_ctrl_pkg;

    localparam logic [11:0] CTRL_OFS = 12'h000;
    localparam logic [11:0] GIE_OFS  = 12'h004;
    localparam logic [11:0] IER_OFS  = 12'h008;
    localparam logic [11:0] ISR_OFS  = 12'h00C;

    localparam logic [9:0] CTRL_WORD = CTRL_OFS[11:2];
    localparam logic [9:0] GIE_WORD  = GIE_OFS[11:2];
    localparam logic [9:0] IER_WORD  = IER_OFS[11:2];
    localparam logic [9:0] ISR_WORD  = ISR_OFS[11:2];

    localparam int unsigned CTRL_AP_START = 0;
    localparam int unsigned CTRL_AP_DONE  = 1;
    localparam int unsigned CTRL_AP_IDLE  = 2;
    localparam int unsigned CTRL_AP_READY = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } kstate_e;

endpackage

// File: rtl/axi_lite_slave_chan.sv
// AXI-Lite channel handling: independent AW/W holding registers, commit strobe,
// B response generation and single-outstanding R channel.
module axi_lite_slave_chan
    import axi_lite_kernel_ctrl_pkg::*;
#(
    parameter int unsigned LITE_DWIDTH = 32,
    parameter int unsigned LITE_AWIDTH = 32
)(
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_awvalid,
    output logic                     o_awready,
    input  logic [LITE_AWIDTH-1:0]   i_awaddr,
    input  logic                     i_wvalid,
    output logic                     o_wready,
    input  logic [LITE_DWIDTH-1:0]   i_wdata,
    input  logic [LITE_DWIDTH/8-1:0] i_wstrb,
    output logic                     o_bvalid,
    input  logic                     i_bready,
    output logic [1:0]               o_bresp,
    input  logic                     i_arvalid,
    output logic                     o_arready,
    input  logic [LITE_AWIDTH-1:0]   i_araddr,
    output logic                     o_rvalid,
    input  logic                     i_rready,
    output logic [LITE_DWIDTH-1:0]   o_rdata,
    output logic [1:0]               o_rresp,
    output logic                     o_wr_en,
    output logic [9:0]               o_wr_addr,
    output logic [LITE_DWIDTH-1:0]   o_wr_data,
    output logic [LITE_DWIDTH/8-1:0] o_wr_strb,
    input  logic                     i_wr_err,
    output logic                     o_rd_en,
    output logic [9:0]               o_rd_addr,
    input  logic [LITE_DWIDTH-1:0]   i_rd_data,
    input  logic                     i_rd_err
);

    logic                     r_aw_held;
    logic [9:0]               r_aw_addr;
    logic                     r_w_held;
    logic [LITE_DWIDTH-1:0]   r_wdata;
    logic [LITE_DWIDTH/8-1:0] r_wstrb;
    logic                     r_bvalid;
    logic [1:0]               r_bresp;
    logic                     r_rvalid;
    logic [LITE_DWIDTH-1:0]   r_rdata;
    logic [1:0]               r_rresp;
    logic                     w_commit;
    logic                     w_unused_addr;

    assign w_unused_addr = &{1'b0, i_awaddr[LITE_AWIDTH-1:12], i_awaddr[1:0],
                             i_araddr[LITE_AWIDTH-1:12], i_araddr[1:0]};

    assign o_awready = ~r_aw_held;
    assign o_wready  = ~r_w_held;
    assign o_arready = ~r_rvalid;
    // A pending B response may be retired in the same cycle the next write commits.
    assign w_commit  = r_aw_held & r_w_held & (~r_bvalid | i_bready);

    assign o_wr_en   = w_commit;
    assign o_wr_addr = r_aw_addr;
    assign o_wr_data = r_wdata;
    assign o_wr_strb = r_wstrb;
    assign o_rd_en   = i_arvalid & ~r_rvalid;
    assign o_rd_addr = i_araddr[11:2];

    assign o_bvalid = r_bvalid;
    assign o_bresp  = r_bresp;
    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;
    assign o_rresp  = r_rresp;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_aw_held <= 1'b0;
            r_aw_addr <= '0;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            if (i_awvalid && !r_aw_held) begin
                r_aw_held <= 1'b1;
                r_aw_addr <= i_awaddr[11:2];
            end else if (w_commit) begin
                r_aw_held <= 1'b0;
            end
            if (i_wvalid && !r_w_held) begin
                r_w_held <= 1'b1;
                r_wdata  <= i_wdata;
                r_wstrb  <= i_wstrb;
            end else if (w_commit) begin
                r_w_held <= 1'b0;
            end
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= i_wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (i_bready) begin
                r_bvalid <= 1'b0;
            end
            if (o_rd_en) begin
                r_rvalid <= 1'b1;
                r_rdata  <= i_rd_data;
                r_rresp  <= i_rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (i_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_lite_kernel_ctrl_slave.sv
// Kernel-side AXI-Lite control slave: HLS-style CTRL/GIE/IER/ISR, parameter and
// result registers, and the IDLE/BUSY start/done sequencer.
module axi_lite_kernel_ctrl_slave
    import axi_lite_kernel_ctrl_pkg::*;
#(
    parameter int unsigned LITE_DWIDTH   = 32,
    parameter int unsigned LITE_AWIDTH   = 32,
    parameter int unsigned PARAM_NUMBER  = 30,
    parameter int unsigned RESULT_NUMBER = 1,
    parameter int unsigned PARAM_BASE    = 'h020,
    parameter int unsigned RESULT_BASE   = 'h100
)(
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [LITE_AWIDTH-1:0]      s_axi_awaddr,
    input  logic [2:0]                  s_axi_awprot,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    input  logic [LITE_DWIDTH-1:0]      s_axi_wdata,
    input  logic [LITE_DWIDTH/8-1:0]    s_axi_wstrb,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    output logic [1:0]                  s_axi_bresp,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    input  logic [LITE_AWIDTH-1:0]      s_axi_araddr,
    input  logic [2:0]                  s_axi_arprot,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [LITE_DWIDTH-1:0]      s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        kernel_start,
    input  logic                        kernel_done,
    output logic [PARAM_NUMBER*32-1:0]  kernel_params,
    input  logic [RESULT_NUMBER*32-1:0] result_data,
    output logic                        interrupt
);

    localparam int unsigned NBYTES    = LITE_DWIDTH / 8;
    localparam logic [9:0]  PARAM_W0  = 10'(PARAM_BASE >> 2);
    localparam logic [9:0]  RESULT_W0 = 10'(RESULT_BASE >> 2);

    logic                   w_wr_en, w_wr_err, w_rd_en, w_rd_err;
    logic [9:0]             w_wr_word, w_rd_word;
    logic [LITE_DWIDTH-1:0] w_wr_data, w_rd_data;
    logic [NBYTES-1:0]      w_wr_strb;
    logic                   w_wr_ctrl, w_wr_gie, w_wr_ier, w_wr_isr, w_wr_param_hit;
    logic                   w_bit0_set, w_ctrl_rd, w_fire, w_done, w_unused_prot;
    kstate_e                r_state, w_state_nxt;
    logic                   r_ap_start, r_ap_done, r_ap_ready, r_gie, r_ier, r_isr;
    logic [31:0]            r_param  [PARAM_NUMBER];
    logic [31:0]            r_result [RESULT_NUMBER];

    assign w_unused_prot = &{1'b0, s_axi_awprot, s_axi_arprot};

    axi_lite_slave_chan #(
        .LITE_DWIDTH (LITE_DWIDTH),
        .LITE_AWIDTH (LITE_AWIDTH)
    ) u_chan (
        .clk       (clk),           .resetn    (resetn),
        .i_awvalid (s_axi_awvalid), .o_awready (s_axi_awready), .i_awaddr (s_axi_awaddr),
        .i_wvalid  (s_axi_wvalid),  .o_wready  (s_axi_wready),
        .i_wdata   (s_axi_wdata),   .i_wstrb   (s_axi_wstrb),
        .o_bvalid  (s_axi_bvalid),  .i_bready  (s_axi_bready),  .o_bresp  (s_axi_bresp),
        .i_arvalid (s_axi_arvalid), .o_arready (s_axi_arready), .i_araddr (s_axi_araddr),
        .o_rvalid  (s_axi_rvalid),  .i_rready  (s_axi_rready),
        .o_rdata   (s_axi_rdata),   .o_rresp   (s_axi_rresp),
        .o_wr_en   (w_wr_en),       .o_wr_addr (w_wr_word),     .o_wr_data (w_wr_data),
        .o_wr_strb (w_wr_strb),     .i_wr_err  (w_wr_err),
        .o_rd_en   (w_rd_en),       .o_rd_addr (w_rd_word),
        .i_rd_data (w_rd_data),     .i_rd_err  (w_rd_err)
    );

    assign w_wr_ctrl  = (w_wr_word == CTRL_WORD);
    assign w_wr_gie   = (w_wr_word == GIE_WORD);
    assign w_wr_ier   = (w_wr_word == IER_WORD);
    assign w_wr_isr   = (w_wr_word == ISR_WORD);
    assign w_wr_err   = ~(w_wr_ctrl | w_wr_gie | w_wr_ier | w_wr_isr | w_wr_param_hit);
    assign w_bit0_set = w_wr_en & w_wr_strb[0] & w_wr_data[0];
    assign w_ctrl_rd  = w_rd_en & (w_rd_word == CTRL_WORD);
    assign w_done     = (r_state == ST_BUSY) & kernel_done;
    assign interrupt  = r_gie & r_isr;

    always_comb begin
        w_wr_param_hit = 1'b0;
        for (int unsigned i = 0; i < PARAM_NUMBER; i++)
            if (w_wr_word == PARAM_W0 + 10'(i)) w_wr_param_hit = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_fire       = 1'b0;
        case (r_state)
            ST_IDLE: if (r_ap_start) begin
                w_fire      = 1'b1;
                w_state_nxt = ST_BUSY;
            end
            ST_BUSY: if (kernel_done) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        kernel_start = w_fire;
    end

    // Set sources take priority over clear-on-read and W1-toggle in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ap_start <= 1'b0;
            r_ap_done  <= 1'b0;
            r_ap_ready <= 1'b0;
            r_gie      <= 1'b0;
            r_ier      <= 1'b0;
            r_isr      <= 1'b0;
            for (int unsigned j = 0; j < RESULT_NUMBER; j++) r_result[j] <= '0;
        end else begin
            r_ap_start <= (w_bit0_set & w_wr_ctrl) | (r_ap_start & ~w_fire);
            r_ap_done  <= w_done | (r_ap_done & ~w_ctrl_rd);
            r_ap_ready <= w_fire | (r_ap_ready & ~w_ctrl_rd);
            if (w_wr_en && w_wr_gie && w_wr_strb[0]) r_gie <= w_wr_data[0];
            if (w_wr_en && w_wr_ier && w_wr_strb[0]) r_ier <= w_wr_data[0];
            r_isr <= (w_done & r_ier) | (r_isr ^ (w_bit0_set & w_wr_isr));
            if (w_done)
                for (int unsigned j = 0; j < RESULT_NUMBER; j++)
                    r_result[j] <= result_data[32*j +: 32];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < PARAM_NUMBER; i++) r_param[i] <= '0;
        end else if (w_wr_en) begin
            for (int unsigned i = 0; i < PARAM_NUMBER; i++)
                for (int unsigned b = 0; b < NBYTES; b++)
                    if (w_wr_word == PARAM_W0 + 10'(i) && w_wr_strb[b])
                        r_param[i][8*b +: 8] <= w_wr_data[8*b +: 8];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < PARAM_NUMBER; i++) kernel_params[32*i +: 32] = r_param[i];
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b1;
        if (w_rd_word == CTRL_WORD) begin
            w_rd_data[CTRL_AP_START] = r_ap_start;
            w_rd_data[CTRL_AP_DONE]  = r_ap_done;
            w_rd_data[CTRL_AP_IDLE]  = (r_state == ST_IDLE);
            w_rd_data[CTRL_AP_READY] = r_ap_ready;
            w_rd_err = 1'b0;
        end
        if (w_rd_word == GIE_WORD) begin w_rd_data[0] = r_gie; w_rd_err = 1'b0; end
        if (w_rd_word == IER_WORD) begin w_rd_data[0] = r_ier; w_rd_err = 1'b0; end
        if (w_rd_word == ISR_WORD) begin w_rd_data[0] = r_isr; w_rd_err = 1'b0; end
        for (int unsigned i = 0; i < PARAM_NUMBER; i++)
            if (w_rd_word == PARAM_W0 + 10'(i)) begin w_rd_data = r_param[i]; w_rd_err = 1'b0; end
        for (int unsigned j = 0; j < RESULT_NUMBER; j++)
            if (w_rd_word == RESULT_W0 + 10'(j)) begin w_rd_data = r_result[j]; w_rd_err = 1'b0; end
    end

endmodule

// File: tb/tb_axi_lite_kernel_ctrl_slave.sv
// Directed self-checking bench for axi_lite_kernel_ctrl_slave.
module tb_axi_lite_kernel_ctrl_slave;

    localparam int unsigned PN = 30;
    localparam int unsigned RN = 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          s_axi_awvalid = 1'b0, s_axi_awready;
    logic [31:0]   s_axi_awaddr = '0;
    logic [2:0]    s_axi_awprot = '0;
    logic          s_axi_wvalid = 1'b0, s_axi_wready;
    logic [31:0]   s_axi_wdata = '0;
    logic [3:0]    s_axi_wstrb = '0;
    logic          s_axi_bvalid, s_axi_bready = 1'b1;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_arvalid = 1'b0, s_axi_arready;
    logic [31:0]   s_axi_araddr = '0;
    logic [2:0]    s_axi_arprot = '0;
    logic          s_axi_rvalid, s_axi_rready = 1'b1;
    logic [31:0]   s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          kernel_start, kernel_done = 1'b0;
    logic [PN*32-1:0] kernel_params;
    logic [RN*32-1:0] result_data = '0;
    logic          interrupt;

    int n_assert = 0;
    int n_fail   = 0;
    int start_cnt = 0;
    int b_cnt    = 0;
    logic [1:0] last_bresp = 2'b00;

    axi_lite_kernel_ctrl_slave #(
        .LITE_DWIDTH(32), .LITE_AWIDTH(32), .PARAM_NUMBER(PN), .RESULT_NUMBER(RN),
        .PARAM_BASE('h020), .RESULT_BASE('h100)
    ) u_dut (
        .clk(clk), .resetn(resetn),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .kernel_start(kernel_start), .kernel_done(kernel_done),
        .kernel_params(kernel_params), .result_data(result_data),
        .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (kernel_start === 1'b1) start_cnt++;
        if (s_axi_bvalid === 1'b1 && s_axi_bready === 1'b1) begin
            b_cnt++;
            last_bresp = s_axi_bresp;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int cyc;
        logic aw_hs, w_hs;
        s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
        cyc = 0;
        while ((s_axi_awvalid || s_axi_wvalid) && cyc < 20) begin
            aw_hs = s_axi_awvalid & s_axi_awready;
            w_hs  = s_axi_wvalid & s_axi_wready;
            tick(); cyc++;
            if (aw_hs) s_axi_awvalid = 1'b0;
            if (w_hs)  s_axi_wvalid  = 1'b0;
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        cyc = 0;
        while (!s_axi_bvalid && cyc < 20) begin tick(); cyc++; end
        chk("wr_bvalid_seen", 32'(s_axi_bvalid), 32'h1);
        resp = s_axi_bresp;
        tick();
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int cyc;
        logic hs;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        cyc = 0;
        while (s_axi_arvalid && cyc < 20) begin
            hs = s_axi_arready;
            tick(); cyc++;
            if (hs) s_axi_arvalid = 1'b0;
        end
        s_axi_arvalid = 1'b0;
        cyc = 0;
        while (!s_axi_rvalid && cyc < 20) begin tick(); cyc++; end
        chk("rd_rvalid_seen", 32'(s_axi_rvalid), 32'h1);
        data = s_axi_rdata;
        resp = s_axi_rresp;
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rsp;
        int b0, s0, cyc;
        logic hs;

        // reset state
        #2;
        chk("rst_awready", 32'(s_axi_awready), 32'h1);
        chk("rst_wready",  32'(s_axi_wready),  32'h1);
        chk("rst_arready", 32'(s_axi_arready), 32'h1);
        chk("rst_bvalid",  32'(s_axi_bvalid),  32'h0);
        chk("rst_rvalid",  32'(s_axi_rvalid),  32'h0);
        chk("rst_kstart",  32'(kernel_start),  32'h0);
        chk("rst_irq",     32'(interrupt),     32'h0);
        chk("rst_kp0",     kernel_params[31:0], 32'h0);
        tick(); tick();
        resetn = 1'b1;
        tick();
        axi_read(32'h000, rd, rsp);
        chk("rst_ctrl_idle", rd, 32'h4);

        // parameter write / read-back
        axi_write(32'h020, 32'hA5A5A5A5, 4'hF, rsp);
        chk("p0_bresp", 32'(rsp), 32'h0);
        axi_read(32'h020, rd, rsp);
        chk("p0_rdata", rd, 32'hA5A5A5A5);
        chk("p0_rresp", 32'(rsp), 32'h0);
        chk("p0_kparams", kernel_params[31:0], 32'hA5A5A5A5);

        // byte strobe
        axi_write(32'h020, 32'hFFFFFFFF, 4'b0010, rsp);
        axi_read(32'h020, rd, rsp);
        chk("p0_strb", rd, 32'hA5A5FFA5);

        // AW three cycles ahead of W
        b0 = b_cnt;
        s_axi_awaddr = 32'h024; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        chk("awfirst_awready_low", 32'(s_axi_awready), 32'h0);
        tick(); tick();
        s_axi_wdata = 32'h11223344; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        tick();
        s_axi_wvalid = 1'b0;
        repeat (6) tick();
        chk("awfirst_bcount", 32'(b_cnt - b0), 32'h1);
        chk("awfirst_bresp", 32'(last_bresp), 32'h0);
        axi_read(32'h024, rd, rsp);
        chk("awfirst_rdata", rd, 32'h11223344);

        // W two cycles ahead of AW
        b0 = b_cnt;
        s_axi_wdata = 32'h55667788; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        tick();
        s_axi_wvalid = 1'b0;
        chk("wfirst_wready_low", 32'(s_axi_wready), 32'h0);
        tick();
        s_axi_awaddr = 32'h028; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        repeat (6) tick();
        chk("wfirst_bcount", 32'(b_cnt - b0), 32'h1);
        chk("wfirst_bresp", 32'(last_bresp), 32'h0);
        axi_read(32'h028, rd, rsp);
        chk("wfirst_rdata", rd, 32'h55667788);

        // B/R backpressure
        b0 = b_cnt;
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        s_axi_awaddr = 32'h02C; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'hCAFEF00D; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        s_axi_araddr = 32'h020; s_axi_arvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        tick();
        s_axi_awaddr = 32'h030; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h0BADBEEF; s_axi_wvalid = 1'b1;
        s_axi_araddr = 32'h02C; s_axi_arvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_bvalid",  32'(s_axi_bvalid),  32'h1);
            chk("bp_bresp",   32'(s_axi_bresp),   32'h0);
            chk("bp_rvalid",  32'(s_axi_rvalid),  32'h1);
            chk("bp_rdata",   s_axi_rdata,        32'hA5A5FFA5);
            chk("bp_awready", 32'(s_axi_awready), 32'h0);
            chk("bp_arready", 32'(s_axi_arready), 32'h0);
            tick();
        end
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        cyc = 0;
        while (s_axi_arvalid && cyc < 10) begin
            hs = s_axi_arready;
            tick(); cyc++;
            if (hs) s_axi_arvalid = 1'b0;
        end
        s_axi_arvalid = 1'b0;
        cyc = 0;
        while (!s_axi_rvalid && cyc < 10) begin tick(); cyc++; end
        chk("bp_rd2_data", s_axi_rdata, 32'hCAFEF00D);
        tick();
        repeat (4) tick();
        chk("bp_bcount", 32'(b_cnt - b0), 32'h2);
        axi_read(32'h030, rd, rsp);
        chk("bp_wr2_data", rd, 32'h0BADBEEF);

        // start / done / interrupt
        axi_write(32'h004, 32'h1, 4'hF, rsp);
        axi_write(32'h008, 32'h1, 4'hF, rsp);
        s0 = start_cnt;
        axi_write(32'h000, 32'h1, 4'hF, rsp);
        axi_read(32'h000, rd, rsp);
        chk("start_ctrl_ready", rd, 32'h8);
        axi_read(32'h000, rd, rsp);
        chk("start_ctrl_cor", rd, 32'h0);
        chk("start_pulse_count", 32'(start_cnt - s0), 32'h1);
        chk("busy_irq_low", 32'(interrupt), 32'h0);
        result_data = 32'h00001234; kernel_done = 1'b1;
        tick();
        kernel_done = 1'b0;
        chk("done_irq", 32'(interrupt), 32'h1);
        axi_read(32'h100, rd, rsp);
        chk("result_rdata", rd, 32'h00001234);
        chk("result_rresp", 32'(rsp), 32'h0);
        axi_read(32'h000, rd, rsp);
        chk("done_ctrl_first", rd, 32'h6);
        axi_read(32'h000, rd, rsp);
        chk("done_ctrl_second", rd, 32'h4);
        axi_write(32'h00C, 32'h1, 4'hF, rsp);
        chk("isr_clear_irq", 32'(interrupt), 32'h0);

        // kernel_done while idle is ignored
        result_data = 32'hDEADBEEF; kernel_done = 1'b1;
        tick();
        kernel_done = 1'b0;
        axi_read(32'h000, rd, rsp);
        chk("idle_done_ctrl", rd, 32'h4);
        axi_read(32'h100, rd, rsp);
        chk("idle_done_result", rd, 32'h00001234);
        chk("idle_done_irq", 32'(interrupt), 32'h0);

        // unmapped and read-only accesses
        axi_read(32'h3FC, rd, rsp);
        chk("unmapped_rdata", rd, 32'h0);
        chk("unmapped_rresp", 32'(rsp), 32'h2);
        axi_write(32'h100, 32'h0000FFFF, 4'hF, rsp);
        chk("ro_bresp", 32'(rsp), 32'h2);
        axi_read(32'h100, rd, rsp);
        chk("ro_unchanged", rd, 32'h00001234);

        // start requested while busy fires after done
        s0 = start_cnt;
        axi_write(32'h000, 32'h1, 4'hF, rsp);
        axi_read(32'h000, rd, rsp);
        chk("lat_first_ctrl", rd, 32'h8);
        axi_write(32'h000, 32'h1, 4'hF, rsp);
        axi_read(32'h000, rd, rsp);
        chk("lat_pending_ctrl", rd, 32'h1);
        chk("lat_no_extra_pulse", 32'(start_cnt - s0), 32'h1);
        result_data = 32'h00005678; kernel_done = 1'b1;
        tick();
        kernel_done = 1'b0;
        tick(); tick();
        chk("lat_second_pulse", 32'(start_cnt - s0), 32'h2);
        axi_read(32'h000, rd, rsp);
        chk("lat_ctrl_done_ready", rd, 32'hA);
        axi_read(32'h000, rd, rsp);
        chk("lat_ctrl_busy", rd, 32'h0);
        kernel_done = 1'b1;
        tick();
        kernel_done = 1'b0;

        // reset mid-transaction drops the held address
        s_axi_awaddr = 32'h020; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        chk("midrst_held", 32'(s_axi_awready), 32'h0);
        resetn = 1'b0;
        #1;
        chk("midrst_awready", 32'(s_axi_awready), 32'h1);
        chk("midrst_bvalid", 32'(s_axi_bvalid), 32'h0);
        chk("midrst_kp0", kernel_params[31:0], 32'h0);
        tick();
        resetn = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
